// File: rtl/min_max_pkg.sv
// ============================================================================
// Module      : min_max_pkg
// Description : Shared types and default widths for the min/max tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package min_max_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // True for the states in which a sample may be accepted.
    function automatic logic is_tracking(input state_e s);
        return (s == FIRST) || (s == TRACK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/Comparator.sv
// ============================================================================
// Module      : Comparator
// Description : Unsigned full-width magnitude comparator (a < b, a > b).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module Comparator
    import min_max_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             gt
);

    assign lt = (a < b);
    assign gt = (a > b);

endmodule

`default_nettype wire

// File: rtl/min_max_tracker.sv
// ============================================================================
// Module      : min_max_tracker
// Description : Tracks min, max and a saturating count over a run of samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module min_max_tracker
    import min_max_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    input  logic             sample_last,
    output logic             sample_ready,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    state_e           r_state;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic w_ready;
    logic w_accept;
    logic w_cnt_sat;
    logic w_lt_min;
    logic w_gt_max;
    logic w_unused_min_gt;
    logic w_unused_max_lt;

    Comparator #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (sample),
        .b  (r_min),
        .lt (w_lt_min),
        .gt (w_unused_min_gt)
    );

    Comparator #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (sample),
        .b  (r_max),
        .lt (w_unused_max_lt),
        .gt (w_gt_max)
    );

    assign w_ready   = is_tracking(r_state);
    assign w_accept  = w_ready && sample_valid;
    assign w_cnt_sat = (r_count == C_CNT_MAX);

    // Control: start is only honoured from IDLE; DONE always lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) r_state <= FIRST;
                end
                FIRST, TRACK: begin
                    if (w_accept) r_state <= sample_last ? DONE : TRACK;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Results change only on start (clear count/ovf) or on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min   <= '0;
            r_max   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                FIRST: begin
                    if (w_accept) begin
                        r_min   <= sample;
                        r_max   <= sample;
                        r_count <= C_CNT_ONE;
                    end
                end
                TRACK: begin
                    if (w_accept) begin
                        if (w_lt_min) r_min <= sample;
                        if (w_gt_max) r_max <= sample;
                        if (w_cnt_sat) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sample_ready = w_ready;
    assign busy         = w_ready;
    assign done         = (r_state == DONE);
    assign min_out      = r_min;
    assign max_out      = r_max;
    assign count        = r_count;
    assign ovf          = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_min_max_tracker.sv
// ============================================================================
// Module      : tb_min_max_tracker
// Description : Directed self-checking bench for min_max_tracker (CNT_W 8 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_min_max_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_last = 1'b0;

    logic        a_ready, a_ovf, a_busy, a_done;
    logic [15:0] a_min, a_max;
    logic [7:0]  a_count;

    logic        b_ready, b_ovf, b_busy, b_done;
    logic [15:0] b_min, b_max;
    logic [1:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    min_max_tracker #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sample(sample),
        .sample_valid(sample_valid), .sample_last(sample_last),
        .sample_ready(a_ready), .min_out(a_min), .max_out(a_max),
        .count(a_count), .ovf(a_ovf), .busy(a_busy), .done(a_done)
    );

    min_max_tracker #(.WIDTH(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sample(sample),
        .sample_valid(sample_valid), .sample_last(sample_last),
        .sample_ready(b_ready), .min_out(b_min), .max_out(b_max),
        .count(b_count), .ovf(b_ovf), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] val, input logic last);
        sample       = val;
        sample_valid = 1'b1;
        sample_last  = last;
        tick();
        sample_valid = 1'b0;
        sample_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_min", a_min, 0);
        check("rst_max", a_max, 0);
        check("rst_count", a_count, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_ready", a_ready, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", a_busy, 0);

        // A valid sample in IDLE is not accepted
        send(16'd77, 1'b0);
        check("idle_noaccept_count", a_count, 0);
        check("idle_noaccept_min", a_min, 0);

        // Basic run: 5, 9, 2, 9, 7(last)
        pulse_start();
        check("first_busy", a_busy, 1);
        check("first_ready", a_ready, 1);
        check("first_count", a_count, 0);
        send(16'd5, 1'b0);
        check("b1_min", a_min, 5);
        check("b1_max", a_max, 5);
        check("b1_count", a_count, 1);
        send(16'd9, 1'b0);
        check("b2_max", a_max, 9);
        check("b2_min", a_min, 5);
        send(16'd2, 1'b0);
        check("b3_min", a_min, 2);
        send(16'd9, 1'b0);
        check("b4_max_eq", a_max, 9);
        check("b4_done", a_done, 0);
        send(16'd7, 1'b1);
        check("basic_done", a_done, 1);
        check("basic_min", a_min, 2);
        check("basic_max", a_max, 9);
        check("basic_count", a_count, 5);
        check("basic_ovf", a_ovf, 0);
        check("basic_busy", a_busy, 0);
        check("basic_ready", a_ready, 0);
        check("basic_sat_count", b_count, 3);
        check("basic_sat_ovf", b_ovf, 1);
        tick();
        check("basic_done_pulse", a_done, 0);
        check("basic_hold_min", a_min, 2);
        check("basic_hold_count", a_count, 5);

        // Single-sample run
        pulse_start();
        check("single_first_busy", a_busy, 1);
        send(16'hFFFF, 1'b1);
        check("single_done", a_done, 1);
        check("single_min", a_min, 16'hFFFF);
        check("single_max", a_max, 16'hFFFF);
        check("single_count", a_count, 1);
        tick();
        check("single_idle_done", a_done, 0);
        check("single_idle_busy", a_busy, 0);

        // Gaps with an ignored start pulse in TRACK
        pulse_start();
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
        end
        start = 1'b0;
        check("gap_count", a_count, 2);
        check("gap_min", a_min, 10);
        check("gap_max", a_max, 20);
        check("gap_busy", a_busy, 1);
        check("gap_done", a_done, 0);
        send(16'd15, 1'b1);
        check("gap_end_done", a_done, 1);
        check("gap_end_count", a_count, 3);
        check("gap_end_min", a_min, 10);
        check("gap_end_max", a_max, 20);
        tick();

        // Saturation: six samples, CNT_W=2 instance saturates
        pulse_start();
        send(16'd3, 1'b0);
        send(16'd1, 1'b0);
        send(16'd4, 1'b0);
        send(16'd1, 1'b0);
        send(16'd5, 1'b0);
        send(16'd9, 1'b1);
        check("sat_done", b_done, 1);
        check("sat_count", b_count, 3);
        check("sat_ovf", b_ovf, 1);
        check("sat_min", b_min, 1);
        check("sat_max", b_max, 9);
        check("wide_count", a_count, 6);
        check("wide_ovf", a_ovf, 0);
        tick();
        check("sat_hold_ovf", b_ovf, 1);
        pulse_start();
        check("sat_clr_count", b_count, 0);
        check("sat_clr_ovf", b_ovf, 0);
        check("sat_clr_min_hold", b_min, 1);
        check("sat_clr_max_hold", b_max, 9);

        // Mid-run reset after three accepts
        send(16'd100, 1'b0);
        send(16'd50, 1'b0);
        send(16'd200, 1'b0);
        check("pre_rst_count", a_count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_min", a_min, 0);
        check("mid_rst_max", a_max, 0);
        check("mid_rst_count", a_count, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_ready", a_ready, 0);
        check("mid_rst_done", a_done, 0);
        check("mid_rst_sat_count", b_count, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", a_busy, 0);
        pulse_start();
        send(16'd8, 1'b0);
        send(16'd8, 1'b0);
        send(16'd3, 1'b1);
        check("rerun_done", a_done, 1);
        check("rerun_min", a_min, 3);
        check("rerun_max", a_max, 8);
        check("rerun_count", a_count, 3);
        check("rerun_ovf", a_ovf, 0);
        tick();
        check("rerun_idle", a_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
